// File: rtl/ahb_switch_in_if.sv
// AHB-Lite bus bundle for the switch-input peripheral.
// The master modport is the bus side; the slave modport is the peripheral.
interface ahb_switch_in_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_switch_in.sv
// Switch/button input block on AHB-Lite: 2-flop synchronizer, tick-paced
// 3-sample debouncer, rising-edge sticky interrupt status with W1C clear.
// Zero wait states; HRDATA is combinational from the registered offset while
// a read is in its data phase and holds the last read value otherwise.
module ahb_switch_in #(
    parameter logic [15:0] DB_RESET = 16'h00FF
) (
    input  logic           clk,
    input  logic           reset,
    ahb_switch_in_if.slave bus,
    input  logic [7:0]     sw_in,
    output logic           irq
);
    localparam logic [2:0] A_DATA     = 3'd0;
    localparam logic [2:0] A_RAW      = 3'd1;
    localparam logic [2:0] A_IRQ_EN   = 3'd2;
    localparam logic [2:0] A_IRQ_STAT = 3'd3;
    localparam logic [2:0] A_DEBOUNCE = 3'd4;

    logic        dp_valid, dp_write;
    logic [2:0]  dp_addr;
    logic        addr_ok, wr_en, rd_en;
    logic [7:0]  sync1, raw;
    logic [7:0]  hist0, hist1, hist2;
    logic [7:0]  hist0_n, hist1_n, hist2_n;
    logic [7:0]  data_q, data_n, rise, w1c;
    logic [7:0]  irq_en, irq_stat;
    logic [15:0] debounce, prescale, db_term;
    logic        tick, db_wr;
    logic [31:0] rd_mux, hrdata_q;
    logic        unused_bus;

    assign addr_ok = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign wr_en   = dp_valid & dp_write;
    assign rd_en   = dp_valid & ~dp_write;
    assign db_wr   = wr_en && (dp_addr == A_DEBOUNCE);

    // Only HADDR[4:2], HTRANS[1] and the low HWDATA bits carry meaning here.
    assign unused_bus = ^{bus.HSIZE, bus.HADDR[31:5], bus.HADDR[1:0],
                          bus.HTRANS[0], bus.HWDATA[31:16]};

    // Register the address phase so the data phase can act on it next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= 3'd0;
        end else begin
            dp_valid <= addr_ok;
            dp_write <= bus.HWRITE;
            dp_addr  <= bus.HADDR[4:2];
        end
    end

    // DEBOUNCE of 0 behaves like 1, so the tick then fires every cycle.
    assign db_term = (debounce == 16'd0) ? 16'd0 : debounce - 16'd1;
    assign tick    = (prescale >= db_term);

    // Prescaler restarts on wrap and whenever DEBOUNCE is rewritten.
    always_ff @(posedge clk) begin
        if (reset)
            prescale <= 16'd0;
        else if (db_wr || tick)
            prescale <= 16'd0;
        else
            prescale <= prescale + 16'd1;
    end

    // Next debounce history, debounced data, rising edges and W1C mask.
    always_comb begin
        hist0_n = hist0;
        hist1_n = hist1;
        hist2_n = hist2;
        data_n  = data_q;
        if (tick) begin
            hist0_n = raw;
            hist1_n = hist0;
            hist2_n = hist1;
            data_n  = (data_q | (hist0_n & hist1_n & hist2_n)) & (hist0_n | hist1_n | hist2_n);
        end
        rise = data_n & ~data_q;
        w1c  = (wr_en && (dp_addr == A_IRQ_STAT)) ? bus.HWDATA[7:0] : 8'h00;
    end

    // Synchronizer, debounce state, status and writable registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 8'h00;
            raw      <= 8'h00;
            hist0    <= 8'h00;
            hist1    <= 8'h00;
            hist2    <= 8'h00;
            data_q   <= 8'h00;
            irq_en   <= 8'h00;
            irq_stat <= 8'h00;
            debounce <= DB_RESET;
        end else begin
            sync1    <= sw_in;
            raw      <= sync1;
            hist0    <= hist0_n;
            hist1    <= hist1_n;
            hist2    <= hist2_n;
            data_q   <= data_n;
            irq_stat <= (irq_stat & ~w1c) | rise;
            if (wr_en && (dp_addr == A_IRQ_EN))
                irq_en <= bus.HWDATA[7:0];
            if (db_wr)
                debounce <= bus.HWDATA[15:0];
        end
    end

    // Read multiplexer over the registered offset.
    always_comb begin
        rd_mux = 32'd0;
        case (dp_addr)
            A_DATA:     rd_mux[7:0]  = data_q;
            A_RAW:      rd_mux[7:0]  = raw;
            A_IRQ_EN:   rd_mux[7:0]  = irq_en;
            A_IRQ_STAT: rd_mux[7:0]  = irq_stat;
            A_DEBOUNCE: rd_mux[15:0] = debounce;
            default:    rd_mux       = 32'd0;
        endcase
    end

    // Hold the last read value so HRDATA stays stable between reads.
    always_ff @(posedge clk) begin
        if (reset)
            hrdata_q <= 32'd0;
        else if (rd_en)
            hrdata_q <= rd_mux;
    end

    assign bus.HRDATA    = rd_en ? rd_mux : hrdata_q;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
    assign irq           = |(irq_stat & irq_en);
endmodule

// File: tb/tb_ahb_switch_in.sv
// Bench for ahb_switch_in: directed scenarios followed by random bus and
// switch activity, all checked every cycle against a behavioural model.
module tb_ahb_switch_in;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_in;
    logic       irq;

    ahb_switch_in_if bus_if();

    ahb_switch_in #(.DB_RESET(16'h00FF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .sw_in (sw_in),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    logic [7:0]  m_s1, m_s2, m_data, m_en, m_stat;
    logic [7:0]  m_smp [3];
    logic [15:0] m_deb;
    int          m_since;
    logic        m_dp_valid, m_dp_write;
    logic [2:0]  m_dp_addr;
    logic [31:0] m_hr;
    logic [31:0] wdata_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_reg(input logic [2:0] a);
        case (a)
            3'd0:    return {24'd0, m_data};
            3'd1:    return {24'd0, m_s2};
            3'd2:    return {24'd0, m_en};
            3'd3:    return {24'd0, m_stat};
            3'd4:    return {16'd0, m_deb};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_data = 0; m_en = 0; m_stat = 0;
        for (int k = 0; k < 3; k++) m_smp[k] = 8'h00;
        m_deb = 16'h00FF; m_since = 0;
        m_dp_valid = 0; m_dp_write = 0; m_dp_addr = 0; m_hr = 0;
    endtask

    // Advance the model by one rising edge using the pre-edge state.
    task automatic model_edge();
        logic [7:0] nd, clr;
        int period;
        bit tk;
        if (reset) begin
            model_reset();
            return;
        end
        if (m_dp_valid && !m_dp_write) m_hr = m_reg(m_dp_addr);
        period = (m_deb == 16'd0) ? 1 : int'(m_deb);
        tk = ((m_since + 1) % period) == 0;
        nd = m_data;
        if (tk) begin
            m_smp[2] = m_smp[1];
            m_smp[1] = m_smp[0];
            m_smp[0] = m_s2;
            for (int b = 0; b < 8; b++)
                if (m_smp[0][b] == m_smp[1][b] && m_smp[1][b] == m_smp[2][b])
                    nd[b] = m_smp[0][b];
        end
        clr = 8'h00;
        m_since = m_since + 1;
        if (m_dp_valid && m_dp_write) begin
            case (m_dp_addr)
                3'd2: m_en = bus_if.HWDATA[7:0];
                3'd3: clr = bus_if.HWDATA[7:0];
                3'd4: begin m_deb = bus_if.HWDATA[15:0]; m_since = 0; end
                default: ;
            endcase
        end
        m_stat = (m_stat & ~clr) | (nd & ~m_data);
        m_data = nd;
        m_s2 = m_s1;
        m_s1 = sw_in;
        m_dp_valid = bus_if.HSEL && bus_if.HREADY && bus_if.HTRANS[1];
        m_dp_write = bus_if.HWRITE;
        m_dp_addr  = bus_if.HADDR[4:2];
    endtask

    task automatic check_outputs();
        logic [31:0] exp_rd;
        exp_rd = (m_dp_valid && !m_dp_write) ? m_reg(m_dp_addr) : m_hr;
        chk("hrdata", bus_if.HRDATA, exp_rd);
        chk("irq", {31'd0, irq}, {31'd0, |(m_stat & m_en)});
        chk("hreadyout", {31'd0, bus_if.HREADYOUT}, 32'd1);
        chk("hresp", {31'd0, bus_if.HRESP}, 32'd0);
    endtask

    // One bus cycle: drive address phase plus data for the previous phase.
    task automatic cyc(input logic sel, input logic [1:0] trans, input logic rdy,
                       input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        bus_if.HSEL   = sel;
        bus_if.HTRANS = trans;
        bus_if.HREADY = rdy;
        bus_if.HWRITE = wr;
        bus_if.HADDR  = addr;
        bus_if.HSIZE  = 3'($urandom);
        bus_if.HWDATA = wdata_pend;
        wdata_pend    = wdata;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 2'b00, 1'b1, 1'($urandom), $urandom, $urandom);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b1, 2'b10, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b1, 2'b10, 1'b1, 1'b0, a, $urandom);
    endtask

    initial begin
        logic [31:0] a, d;
        int op;
        reset = 1'b1;
        sw_in = 8'h00;
        wdata_pend = 32'd0;
        bus_if.HSEL = 0; bus_if.HTRANS = 0; bus_if.HREADY = 1; bus_if.HWRITE = 0;
        bus_if.HADDR = 0; bus_if.HSIZE = 3'b010; bus_if.HWDATA = 0;
        model_reset();
        @(negedge clk);
        idle(3);
        reset = 1'b0;

        // Reset values
        rd(32'h10); chk("rst_debounce", bus_if.HRDATA, 32'h000000FF);
        rd(32'h00); chk("rst_data", bus_if.HRDATA, 32'd0);
        rd(32'h08); chk("rst_irq_en", bus_if.HRDATA, 32'd0);
        rd(32'h0C); chk("rst_irq_stat", bus_if.HRDATA, 32'd0);

        // Stable input with DEBOUNCE=4
        wr(32'h10, 32'd4); idle(1);
        sw_in = 8'h01;
        idle(2);
        rd(32'h04); chk("raw_sync", bus_if.HRDATA, 32'h01);
        idle(16);
        rd(32'h00); chk("data_debounced", bus_if.HRDATA, 32'h01);
        rd(32'h0C); chk("stat_set", bus_if.HRDATA, 32'h01);

        // Interrupt enable and W1C
        wr(32'h08, 32'h01); idle(1);
        chk("irq_on", {31'd0, irq}, 32'd1);
        wr(32'h0C, 32'h01); idle(1);
        chk("irq_w1c", {31'd0, irq}, 32'd0);
        rd(32'h0C); chk("stat_cleared", bus_if.HRDATA, 32'd0);

        // Glitch shorter than the debounce window
        sw_in = 8'h00; idle(20);
        rd(32'h00); chk("data_low", bus_if.HRDATA, 32'd0);
        sw_in = 8'h01; idle(5);
        sw_in = 8'h00; idle(20);
        rd(32'h00); chk("glitch_data", bus_if.HRDATA, 32'd0);
        rd(32'h0C); chk("glitch_stat", bus_if.HRDATA, 32'd0);

        // Rising edge lands on the same edge as a W1C of that bit
        wr(32'h10, 32'd0); idle(1);
        sw_in = 8'h01;
        idle(3);
        wr(32'h0C, 32'h01); idle(1);
        rd(32'h0C); chk("set_wins", bus_if.HRDATA, 32'h01);

        // Back-to-back write/read, unmapped offset, read-only DATA
        wr(32'h08, 32'hA5);
        rd(32'h08); chk("b2b_read", bus_if.HRDATA, 32'h000000A5);
        rd(32'h18); chk("unmapped", bus_if.HRDATA, 32'd0);
        wr(32'h00, 32'hFF); idle(1);
        rd(32'h00); chk("data_ro", bus_if.HRDATA, 32'h01);

        // DEBOUNCE=0: tick every cycle, then reset mid-transfer
        sw_in = 8'h00; idle(10);
        sw_in = 8'hFF; idle(4);
        rd(32'h00); chk("fast_data", bus_if.HRDATA, 32'hFF);
        wr(32'h08, 32'h5A);
        reset = 1'b1; idle(1);
        chk("hrdata_rst", bus_if.HRDATA, 32'd0);
        chk("irq_rst", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        rd(32'h08); chk("abort_irq_en", bus_if.HRDATA, 32'd0);
        rd(32'h10); chk("rst2_debounce", bus_if.HRDATA, 32'h000000FF);
        rd(32'h00); chk("rst2_data", bus_if.HRDATA, 32'd0);
        rd(32'h0C); chk("rst2_stat", bus_if.HRDATA, 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0)
                sw_in = 8'($urandom);
            else if ($urandom_range(0, 29) == 0)
                sw_in = sw_in ^ (8'h01 << $urandom_range(0, 7));
            reset = ($urandom_range(0, 599) == 0);
            a = $urandom;
            d = $urandom;
            if (a[4:2] == 3'd4) d[15:0] = 16'($urandom_range(0, 5));
            op = $urandom_range(0, 9);
            if (op < 3)
                wr(a, d);
            else if (op < 6)
                rd(a);
            else if (op < 8)
                cyc(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), a, d);
            else
                idle(1);
        end
        reset = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_switch_in.md
AHB_SWITCH_IN -- requirements
Module: ahb_switch_in

Interface
REQ-001 Parameter DB_RESET, default 16'h00FF: reset value of the DEBOUNCE register.
REQ-002 clk  input  1  single clock; all flops are rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 HSEL  input  1  AHB-Lite slave select.
REQ-005 HADDR  input  32  address; only HADDR[4:2] is decoded.
REQ-006 HTRANS  input  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
REQ-007 HWRITE  input  1  1=write, 0=read.
REQ-008 HSIZE  input  3  ignored; all accesses are treated as word accesses.
REQ-009 HWDATA  input  32  write data, sampled in the data phase.
REQ-010 HREADY  input  1  bus-ready qualifier for the address phase.
REQ-011 HRDATA  output  32  read data, valid in the data phase.
REQ-012 HREADYOUT  output  1  constant 1; the block inserts zero wait states.
REQ-013 HRESP  output  1  constant 0 (OKAY).
REQ-014 sw_in  input  8  asynchronous switch/button inputs.
REQ-015 irq  output  1  level interrupt to the CPU.

Function
REQ-016 Address phase accepted when HSEL & HREADY & HTRANS[1]; HWRITE and HADDR[4:2] are registered; the data phase is the next cycle.
REQ-017 Register map (word offsets): 0x00 DATA RO[7:0] debounced; 0x04 RAW RO[7:0] synchronized; 0x08 IRQ_EN RW[7:0]; 0x0C IRQ_STAT RO/W1C[7:0]; 0x10 DEBOUNCE RW[15:0]; unused bits and offsets 0x14-0x1C read 0, and writes to them are ignored.
REQ-018 Read: HRDATA is driven from the registered offset during the data phase, and holds its value when no read is in its data phase.
REQ-019 Write: the register update uses HWDATA on the clock edge ending the data phase; back-to-back transfers every cycle are supported.
REQ-020 Synchronizer: each sw_in bit passes through a 2-flop synchronizer; RAW = second stage.
REQ-021 Tick: a 16-bit prescaler counts 0..max(DEBOUNCE,1)-1 and pulses tick for one cycle at wrap; a write to DEBOUNCE clears the prescaler on the same edge.
REQ-022 Debounce: on each tick, each bit shifts RAW into its own 3-sample history; when all 3 samples are equal and differ from DATA, the DATA bit takes that value on the same edge.
REQ-023 Edge detect: on the edge where a DATA bit changes 0->1, the corresponding IRQ_STAT bit is set (sticky); 1->0 transitions do not set it.
REQ-024 W1C: writing 1 to an IRQ_STAT bit clears it; if a set and a clear hit the same bit on the same edge, the set wins.
REQ-025 irq = |(IRQ_STAT & IRQ_EN), derived combinationally from flops only; the IRQ_EN mask does not gate the setting of IRQ_STAT bits.
REQ-026 Latency: an sw_in change held stable reaches DATA after 2 sync cycles plus 3 to 4 ticks.

Reset
REQ-027 While reset=1 on a clock edge: sync flops, histories, DATA, IRQ_EN, IRQ_STAT, prescaler, registered address-phase state and HRDATA all go to 0, and DEBOUNCE goes to DB_RESET.
REQ-028 Reset asserted mid-transfer aborts the pending data phase; no register is written, and HRDATA reads 0 on the following cycle.
REQ-029 After reset deasserts, the first tick occurs DEBOUNCE cycles later; irq is 0 throughout reset.

Verification
REQ-030 Reset, then read 0x10 -> 0x000000FF; read 0x00, 0x08 and 0x0C -> 0; HREADYOUT=1 and HRESP=0 throughout.
REQ-031 DEBOUNCE=4, sw_in=8'h01 held stable -> RAW=0x01 after 2 cycles; DATA=0x01 within 2+16 cycles; IRQ_STAT=0x01.
REQ-032 DEBOUNCE=4, sw_in bit0 glitches high for 5 cycles then returns low -> DATA stays 0x00 and IRQ_STAT stays 0.
REQ-033 IRQ_EN=0x01 with IRQ_STAT bit0 set -> irq=1; write 0x0C=0x01 -> IRQ_STAT=0 and irq=0 on the next cycle; a new rising edge coincident with the W1C write -> the bit remains 1.
REQ-034 Back-to-back write 0x08=0xA5 then read 0x08 on consecutive cycles -> HRDATA=0x000000A5; read of 0x18 -> 0; write 0x00=0xFF -> DATA is unchanged.
REQ-035 DEBOUNCE=0 -> tick fires every cycle; sw_in=8'hFF -> DATA=0xFF in 5-6 cycles; asserting reset mid-sequence -> all registers return to their reset values.
